filter_tap_loader: RTL and testbench

//   Control-side writer for the FIR filter tap port: accepts a coefficient stream into a shadow bank,

---
 rtl/filter_tap_loader.sv | 183 ++++++++++++++++++
 tb/tb_filter_tap_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/filter_tap_loader.sv
// Coefficient shadow bank plus a load sequencer for one FIR filter tap port:
// collect a coefficient set, then on commit stall samples, write every tap and flush the filter.
module filter_tap_loader #(
    parameter int unsigned N_TAPS     = 9,
    parameter int unsigned TAP_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_coeff_valid,
    output logic                  o_coeff_ready,
    input  logic [TAP_WIDTH-1:0]  i_coeff_data,
    input  logic                  i_coeff_last,
    input  logic                  i_commit,
    output logic [ADDR_WIDTH-1:0] o_tap_address,
    output logic [TAP_WIDTH-1:0]  o_tap_data,
    output logic                  o_tap_we,
    output logic                  o_pipeline_flush,
    output logic                  o_stream_hold,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_commit_rejected,
    output logic                  o_length_error
);

    localparam int unsigned CNT_W = $clog2(N_TAPS + 1);
    localparam int unsigned IDX_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_WRITE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_wr_ptr;
    logic                  r_in_set;
    logic                  r_bank_valid;
    logic                  r_length_error;
    logic [TAP_WIDTH-1:0]  r_bank [N_TAPS];
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_tap_address;
    logic [TAP_WIDTH-1:0]  r_tap_data;
    logic                  r_tap_we;
    logic                  r_flush;
    logic                  r_hold;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_rejected;
    logic                  r_ready;

    logic                  w_accept;
    logic                  w_set_ok;
    logic                  w_start;
    logic [ADDR_WIDTH-1:0] w_rd_next;

    // r_ready mirrors state==IDLE, so beats are only ever taken while idle
    assign w_accept  = i_coeff_valid & r_ready;
    // wr_ptr saturates at N_TAPS, so N_TAPS-1 on the last beat means exactly N_TAPS beats
    assign w_set_ok  = (r_wr_ptr == CNT_W'(N_TAPS - 1));
    assign w_start   = (r_state == S_IDLE) & i_commit & r_bank_valid & ~w_accept;
    assign w_rd_next = r_rd_ptr + ADDR_WIDTH'(1);

    // Shadow bank storage; contents are don't-care out of reset
    always_ff @(posedge i_clk) begin
        if (w_accept && (r_wr_ptr < CNT_W'(N_TAPS))) begin
            r_bank[IDX_W'(r_wr_ptr)] <= i_coeff_data;
        end
    end

    // Coefficient set tracking: beat count, set validity and length error
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr       <= '0;
            r_in_set       <= 1'b0;
            r_bank_valid   <= 1'b0;
            r_length_error <= 1'b0;
        end else if (w_accept) begin
            if (i_coeff_last) begin
                r_wr_ptr       <= '0;
                r_in_set       <= 1'b0;
                r_bank_valid   <= w_set_ok;
                r_length_error <= ~w_set_ok;
            end else begin
                r_in_set <= 1'b1;
                if (r_wr_ptr != CNT_W'(N_TAPS)) begin
                    r_wr_ptr <= r_wr_ptr + CNT_W'(1);
                end
                if (!r_in_set) begin
                    r_bank_valid   <= 1'b0;
                    r_length_error <= 1'b0;
                end
            end
        end
    end

    // Load sequencer; every control output is a flop loaded on the transition into its state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_rd_ptr      <= '0;
            r_tap_address <= '0;
            r_tap_data    <= '0;
            r_tap_we      <= 1'b0;
            r_flush       <= 1'b0;
            r_hold        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rejected    <= 1'b0;
            r_ready       <= 1'b1;
        end else begin
            r_done     <= 1'b0;
            r_rejected <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_HOLD;
                        r_hold  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                    end else if (i_commit) begin
                        r_rejected <= 1'b1;
                    end
                end
                S_HOLD: begin
                    r_state       <= S_WRITE;
                    r_rd_ptr      <= '0;
                    r_tap_we      <= 1'b1;
                    r_tap_address <= '0;
                    r_tap_data    <= r_bank[0];
                end
                S_WRITE: begin
                    if (r_rd_ptr == ADDR_WIDTH'(N_TAPS - 1)) begin
                        r_state       <= S_FLUSH;
                        r_tap_we      <= 1'b0;
                        r_tap_address <= '0;
                        r_tap_data    <= '0;
                        r_flush       <= 1'b1;
                    end else begin
                        r_rd_ptr      <= w_rd_next;
                        r_tap_address <= w_rd_next;
                        r_tap_data    <= r_bank[IDX_W'(w_rd_next)];
                    end
                end
                S_FLUSH: begin
                    r_state <= S_DONE;
                    r_flush <= 1'b0;
                    r_hold  <= 1'b0;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_tap_we      <= 1'b0;
                    r_tap_address <= '0;
                    r_tap_data    <= '0;
                    r_flush       <= 1'b0;
                    r_hold        <= 1'b0;
                    r_busy        <= 1'b0;
                    r_ready       <= 1'b1;
                end
            endcase
        end
    end

    assign o_coeff_ready     = r_ready;
    assign o_tap_address     = r_tap_address;
    assign o_tap_data        = r_tap_data;
    assign o_tap_we          = r_tap_we;
    assign o_pipeline_flush  = r_flush;
    assign o_stream_hold     = r_hold;
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_commit_rejected = r_rejected;
    assign o_length_error    = r_length_error;

endmodule

// File: tb/tb_filter_tap_loader.sv
// Directed bench for filter_tap_loader: per-cycle control timing plus a tap-write scoreboard.
module tb_filter_tap_loader;

    localparam int unsigned N  = 9;
    localparam int unsigned TW = 16;
    localparam int unsigned AW = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [TW-1:0] data;
    } tap_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          coeff_valid;
    logic          coeff_ready;
    logic [TW-1:0] coeff_data;
    logic          coeff_last;
    logic          commit;
    logic [AW-1:0] tap_address;
    logic [TW-1:0] tap_data;
    logic          tap_we;
    logic          pipeline_flush;
    logic          stream_hold;
    logic          busy;
    logic          done;
    logic          commit_rejected;
    logic          length_error;

    int            total = 0;
    int            bad   = 0;
    tap_t          sb_q[$];
    logic [TW-1:0] gold [N];
    bit            gold_valid = 1'b0;

    filter_tap_loader #(.N_TAPS(N), .TAP_WIDTH(TW), .ADDR_WIDTH(AW)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_coeff_valid    (coeff_valid),
        .o_coeff_ready    (coeff_ready),
        .i_coeff_data     (coeff_data),
        .i_coeff_last     (coeff_last),
        .i_commit         (commit),
        .o_tap_address    (tap_address),
        .o_tap_data       (tap_data),
        .o_tap_we         (tap_we),
        .o_pipeline_flush (pipeline_flush),
        .o_stream_hold    (stream_hold),
        .o_busy           (busy),
        .o_done           (done),
        .o_commit_rejected(commit_rejected),
        .o_length_error   (length_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ctl_vec();
        return {stream_hold, tap_we, pipeline_flush, done, busy, coeff_ready, commit_rejected};
    endfunction

    // Tap-port monitor: every write strobe must match the next queued expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (tap_we) begin
                if (sb_q.size() == 0) begin
                    check("tap_we_unexpected", 32'(tap_we), 32'(0));
                end else begin
                    tap_t e;
                    e = sb_q.pop_front();
                    check("tap_addr", 32'(tap_address), 32'(e.addr));
                    check("tap_data", 32'(tap_data), 32'(e.data));
                end
            end else begin
                check("tap_idle_zero", 32'({tap_address, tap_data}), 32'(0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_set(input int n, input logic [TW-1:0] base, input bit commit_on_last);
        for (int k = 0; k < n; k++) begin
            coeff_valid = 1'b1;
            coeff_data  = base + TW'(k);
            coeff_last  = (k == n - 1);
            commit      = commit_on_last && (k == n - 1);
            if (n == N) gold[k] = base + TW'(k);
            tick();
        end
        coeff_valid = 1'b0;
        coeff_last  = 1'b0;
        coeff_data  = '0;
        commit      = 1'b0;
        gold_valid  = (n == N);
        check("length_error", 32'(length_error), 32'(n != N));
    endtask

    // Commit at edge 0 and check the control outputs cycle by cycle up to reset_at (0 = full run)
    task automatic run_commit(input bit expect_ok, input bit inject, input int reset_at);
        logic [6:0] exp;
        int         last_c;
        if (expect_ok) begin
            for (int k = 0; k < N; k++) sb_q.push_back('{addr: AW'(k), data: gold[k]});
        end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        last_c = (reset_at != 0) ? reset_at - 1 : N + 4;
        for (int c = 1; c <= last_c; c++) begin
            if (expect_ok) begin
                exp = {(c >= 1 && c <= N + 2), (c >= 2 && c <= N + 1), (c == N + 2),
                       (c == N + 3), (c >= 1 && c <= N + 3), !(c >= 1 && c <= N + 3), 1'b0};
            end else begin
                exp = {5'b0, 1'b1, (c == 1)};
            end
            check($sformatf("ctl_c%0d", c), 32'(ctl_vec()), 32'(exp));
            if (inject && c == 5) begin
                commit      = 1'b1;
                coeff_valid = 1'b1;
                coeff_data  = 16'hdead;
                coeff_last  = 1'b1;
            end
            tick();
            commit      = 1'b0;
            coeff_valid = 1'b0;
            coeff_last  = 1'b0;
            coeff_data  = '0;
        end
        if (reset_at == 0) check("sb_drained", 32'(sb_q.size()), 32'(0));
    endtask

    initial begin
        rst_n       = 1'b0;
        coeff_valid = 1'b0;
        coeff_data  = '0;
        coeff_last  = 1'b0;
        commit      = 1'b0;
        #12;
        check("reset_ctl", 32'(ctl_vec()), 32'(7'b0000010));
        check("reset_len_err", 32'(length_error), 32'(0));
        check("reset_tap", 32'({tap_address, tap_data}), 32'(0));
        #5 rst_n = 1'b1;
        tick();

        // Nominal set 1..9 then load
        send_set(N, 16'd1, 1'b0);
        run_commit(1'b1, 1'b0, 0);

        // Short set: length error, commit refused
        send_set(8, 16'h0100, 1'b0);
        run_commit(1'b0, 1'b0, 0);

        // Long set, then a good set clears the error and loads
        send_set(12, 16'h0200, 1'b0);
        run_commit(1'b0, 1'b0, 0);
        send_set(N, 16'h8000, 1'b0);
        run_commit(1'b1, 1'b0, 0);

        // Commit and a beat during WRITE are ignored
        run_commit(1'b1, 1'b1, 0);

        // Replay without a new stream
        run_commit(1'b1, 1'b0, 0);

        // Commit coinciding with an accepted beat is refused
        send_set(N, 16'h7ff0, 1'b1);
        check("commit_with_beat_rej", 32'(commit_rejected), 32'(1));
        check("commit_with_beat_idle", 32'(busy), 32'(0));
        run_commit(1'b1, 1'b0, 0);

        // Reset in the middle of a load
        run_commit(1'b1, 1'b0, 5);
        rst_n = 1'b0;
        #1;
        check("midreset_ctl", 32'(ctl_vec() & 7'b1111101), 32'(0));
        check("midreset_tap", 32'({tap_address, tap_data}), 32'(0));
        sb_q.delete();
        #8 rst_n = 1'b1;
        tick();
        check("post_reset_ready", 32'(coeff_ready), 32'(1));
        check("post_reset_len_err", 32'(length_error), 32'(0));
        run_commit(1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
